// File: rtl/motor_bridge_driver_pkg.sv
// motor_bridge_driver_pkg: shared direction codes, channel states and helpers
// for the H-bridge driver and its per-channel controller.
package motor_bridge_driver_pkg;
   localparam logic [1:0] DIR_FWD  = 2'b10;
   localparam logic [1:0] DIR_REV  = 2'b01;
   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam int LEFT  = 1;
   localparam int RIGHT = 0;
   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DEAD} state_t;
   function automatic logic is_valid(input logic en, input logic [1:0] dir);
      return en && (dir == DIR_FWD || dir == DIR_REV);
   endfunction
endpackage

// File: rtl/motor_bridge_driver_channel.sv
// motor_bridge_driver_channel: one H-bridge channel -- STOP/RUN/DEAD FSM,
// dead-time counter, soft-start ramp and registered bridge outputs.
module motor_bridge_driver_channel
   import motor_bridge_driver_pkg::*;
#(
   parameter int PWM_BITS    = 8,
   parameter int DEAD_CYCLES = 1000,
   parameter int RAMP_DIV    = 1000,
   parameter int RAMP_STEP   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          i_dir,
   input  logic                i_en,
   input  logic [PWM_BITS-1:0] i_target,
   input  logic [PWM_BITS-1:0] i_cnt,
   output logic [1:0]          o_hb_in,
   output logic                o_hb_en,
   output logic                o_dead_busy
);
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam int RW = $clog2(RAMP_DIV + 1);
   state_t              r_state, w_state;
   logic [1:0]          r_dir, w_dir;
   logic [PWM_BITS-1:0] r_level, w_level;
   logic [DW-1:0]       r_dead, w_dead;
   logic [RW-1:0]       r_pre, w_pre;
   logic                w_valid, w_tick;
   logic [PWM_BITS:0]   w_sum;
   assign w_valid = is_valid(i_en, i_dir);
   assign w_tick  = r_pre == RW'(RAMP_DIV - 1);
   // one extra bit so the ramp add saturates instead of wrapping
   assign w_sum   = {1'b0, r_level} + (PWM_BITS+1)'(RAMP_STEP);
   always_comb begin
      w_state = r_state;
      w_dir   = r_dir;
      w_level = r_level;
      w_dead  = r_dead;
      w_pre   = r_pre;
      case (r_state)
         ST_STOP: if (w_valid) begin
            w_state = ST_RUN;
            w_dir   = i_dir;
            w_level = '0;
            w_pre   = '0;
         end
         ST_RUN: if (!(i_en && i_dir == r_dir)) begin
            w_state = ST_DEAD;
            w_dead  = DW'(DEAD_CYCLES);
            w_level = '0;
         end else begin
            w_pre = w_tick ? '0 : r_pre + RW'(1);
            if (i_target < r_level)
               w_level = i_target;
            else if (w_tick)
               w_level = (w_sum > {1'b0, i_target}) ? i_target : w_sum[PWM_BITS-1:0];
         end
         ST_DEAD: if (r_dead == DW'(1)) begin
            w_dead  = '0;
            w_state = w_valid ? ST_RUN : ST_STOP;
            w_dir   = w_valid ? i_dir : r_dir;
            w_level = '0;
            w_pre   = '0;
         end else begin
            w_dead = r_dead - DW'(1);
         end
         default: w_state = ST_STOP;
      endcase
   end
   // outputs are registered from the next state so they line up with it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_STOP;
         r_dir       <= DIR_STOP;
         r_level     <= '0;
         r_dead      <= '0;
         r_pre       <= '0;
         o_hb_in     <= DIR_STOP;
         o_hb_en     <= 1'b0;
         o_dead_busy <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_dir       <= w_dir;
         r_level     <= w_level;
         r_dead      <= w_dead;
         r_pre       <= w_pre;
         o_hb_in     <= (w_state == ST_RUN) ? w_dir : DIR_STOP;
         o_hb_en     <= (w_state == ST_RUN) && (i_cnt < w_level);
         o_dead_busy <= w_state == ST_DEAD;
      end
   end
endmodule

// File: rtl/motor_bridge_driver.sv
// motor_bridge_driver: registers the motor decision inputs, runs the shared
// PWM counter and drives two independent dead-time-protected bridge channels.
module motor_bridge_driver
   import motor_bridge_driver_pkg::*;
#(
   parameter int PWM_BITS    = 8,
   parameter int DEAD_CYCLES = 1000,
   parameter int RAMP_DIV    = 1000,
   parameter int RAMP_STEP   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            motorIn,
   input  logic [1:0]            motorEn,
   input  logic [2*PWM_BITS-1:0] duty,
   output logic [3:0]            hbIn,
   output logic [1:0]            hbEn,
   output logic [1:0]            deadBusy
);
   localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'(2**PWM_BITS - 2);
   logic [3:0]            r_in;
   logic [1:0]            r_en;
   logic [2*PWM_BITS-1:0] r_duty;
   logic [PWM_BITS-1:0]   r_cnt;
   // period is 2^PWM_BITS-1 so a full-scale level reads as constant high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in   <= '0;
         r_en   <= '0;
         r_duty <= '0;
         r_cnt  <= '0;
      end else begin
         r_in   <= motorIn;
         r_en   <= motorEn;
         r_duty <= duty;
         r_cnt  <= (r_cnt == CNT_MAX) ? '0 : r_cnt + PWM_BITS'(1);
      end
   end
   motor_bridge_driver_channel #(
      .PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)
   ) u_right (
      .clk(clk), .rst_n(rst_n),
      .i_dir(r_in[2*RIGHT +: 2]), .i_en(r_en[RIGHT]),
      .i_target(r_duty[PWM_BITS*RIGHT +: PWM_BITS]), .i_cnt(r_cnt),
      .o_hb_in(hbIn[2*RIGHT +: 2]), .o_hb_en(hbEn[RIGHT]), .o_dead_busy(deadBusy[RIGHT])
   );
   motor_bridge_driver_channel #(
      .PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)
   ) u_left (
      .clk(clk), .rst_n(rst_n),
      .i_dir(r_in[2*LEFT +: 2]), .i_en(r_en[LEFT]),
      .i_target(r_duty[PWM_BITS*LEFT +: PWM_BITS]), .i_cnt(r_cnt),
      .o_hb_in(hbIn[2*LEFT +: 2]), .o_hb_en(hbEn[LEFT]), .o_dead_busy(deadBusy[LEFT])
   );
endmodule

// File: tb/tb_motor_bridge_driver.sv
// tb_motor_bridge_driver: directed scenarios for the bridge driver with a
// shoot-through / dead-time watch applied on every sampled cycle.
module tb_motor_bridge_driver;
   localparam int PW = 8, DC = 4, RD = 2, RS = 64;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] motorIn = '0;
   logic [1:0] motorEn = '0;
   logic [2*PW-1:0] duty = '0;
   logic [3:0] hbIn;
   logic [1:0] hbEn, deadBusy;
   int total = 0, bad = 0;
   logic [1:0] last_nz [2];
   int zrun [2];
   logic [1:0] pair;
   always #5 clk = ~clk;
   motor_bridge_driver #(.PWM_BITS(PW), .DEAD_CYCLES(DC), .RAMP_DIV(RD), .RAMP_STEP(RS)) dut (
      .clk(clk), .rst_n(rst_n), .motorIn(motorIn), .motorEn(motorEn), .duty(duty),
      .hbIn(hbIn), .hbEn(hbEn), .deadBusy(deadBusy)
   );
   // sample 1 time unit after each edge and watch for illegal bridge pairs
   task automatic tick();
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         pair = hbIn[2*m +: 2];
         if (!rst_n) begin
            last_nz[m] = 2'b00;
            zrun[m] = 0;
         end else if (pair == 2'b11) begin
            total++; bad++;
            $display("FAIL shoot_through ch%0d got=%b required=not 11", m, pair);
         end else if (pair == 2'b00) begin
            zrun[m]++;
         end else begin
            if (last_nz[m] != 2'b00 && last_nz[m] != pair) begin
               total++;
               if (zrun[m] < DC) begin
                  bad++;
                  $display("FAIL dead_gap ch%0d got=%0d required>=%0d", m, zrun[m], DC);
               end
            end
            last_nz[m] = pair;
            zrun[m] = 0;
         end
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0; motorIn = '0; motorEn = '0; duty = '0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask
   task automatic measure(output int r, output int l);
      r = 0; l = 0;
      repeat (255) begin
         tick();
         r += int'(hbEn[0]);
         l += int'(hbEn[1]);
      end
   endtask
   task automatic test_reset();
      rst_n = 1'b0; motorIn = 4'b1010; motorEn = 2'b11; duty = '0;
      repeat (3) tick();
      total++; if (hbIn !== 4'b0000) begin bad++; $display("FAIL reset_hbIn got=%b required=0000", hbIn); end
      total++; if (hbEn !== 2'b00) begin bad++; $display("FAIL reset_hbEn got=%b required=00", hbEn); end
      total++; if (deadBusy !== 2'b00) begin bad++; $display("FAIL reset_deadBusy got=%b required=00", deadBusy); end
      rst_n = 1'b1;
      tick();
      total++; if (hbIn !== 4'b0000) begin bad++; $display("FAIL release_1clk got=%b required=0000", hbIn); end
      tick();
      total++; if (hbIn !== 4'b1010) begin bad++; $display("FAIL release_2clk got=%b required=1010", hbIn); end
   endtask
   task automatic test_soft_start();
      int r, l;
      do_reset();
      duty = 16'h00FF; motorEn = 2'b01; motorIn = 4'b0010;
      tick();
      tick();
      total++; if (hbIn !== 4'b0010 || hbEn[0] !== 1'b0) begin bad++; $display("FAIL ss_enter got=%b/%b required=0010/0", hbIn, hbEn[0]); end
      tick();
      total++; if (hbEn[0] !== 1'b0) begin bad++; $display("FAIL ss_level0 got=%b required=0", hbEn[0]); end
      tick();
      total++; if (hbEn[0] !== 1'b1) begin bad++; $display("FAIL ss_level64 got=%b required=1", hbEn[0]); end
      repeat (10) tick();
      measure(r, l);
      total++; if (r != 255 || l != 0) begin bad++; $display("FAIL ss_full got=%0d/%0d required=255/0", r, l); end
   endtask
   task automatic test_ramp_clamp();
      int r, l;
      do_reset();
      duty = 16'h0064; motorEn = 2'b11; motorIn = 4'b1010;
      repeat (12) tick();
      total++; if (hbIn !== 4'b1010) begin bad++; $display("FAIL clamp_dir got=%b required=1010", hbIn); end
      measure(r, l);
      total++; if (r != 100) begin bad++; $display("FAIL clamp_right got=%0d required=100", r); end
      total++; if (l != 0) begin bad++; $display("FAIL clamp_left_zero got=%0d required=0", l); end
   endtask
   task automatic test_reversal();
      int r, l;
      do_reset();
      duty = 16'h80FF; motorEn = 2'b11; motorIn = 4'b1010;
      repeat (14) tick();
      measure(r, l);
      total++; if (r != 255 || l != 128) begin bad++; $display("FAIL rev_pre got=%0d/%0d required=255/128", r, l); end
      motorIn = 4'b1001;
      tick();
      total++; if (hbIn !== 4'b1010 || deadBusy !== 2'b00) begin bad++; $display("FAIL rev_latency got=%b/%b required=1010/00", hbIn, deadBusy); end
      for (int i = 0; i < DC; i++) begin
         tick();
         total++;
         if (hbIn !== 4'b1000 || deadBusy !== 2'b01 || hbEn[0] !== 1'b0) begin
            bad++; $display("FAIL rev_dead%0d got=%b/%b/%b required=1000/01/0", i, hbIn, deadBusy, hbEn[0]);
         end
      end
      tick();
      total++; if (hbIn !== 4'b1001 || deadBusy !== 2'b00 || hbEn[0] !== 1'b0) begin bad++; $display("FAIL rev_run got=%b/%b/%b required=1001/00/0", hbIn, deadBusy, hbEn[0]); end
      tick();
      total++; if (hbEn[0] !== 1'b0) begin bad++; $display("FAIL rev_level0 got=%b required=0", hbEn[0]); end
      repeat (10) tick();
      measure(r, l);
      total++; if (r != 255 || l != 128) begin bad++; $display("FAIL rev_post got=%0d/%0d required=255/128", r, l); end
   endtask
   task automatic test_glitch();
      do_reset();
      duty = 16'h00FF; motorEn = 2'b01; motorIn = 4'b0010;
      repeat (12) tick();
      motorIn = 4'b0001;
      tick();
      total++; if (hbIn !== 4'b0010) begin bad++; $display("FAIL gl_latency got=%b required=0010", hbIn); end
      motorIn = 4'b0010;
      for (int i = 0; i < DC; i++) begin
         tick();
         total++;
         if (hbIn !== 4'b0000 || deadBusy !== 2'b01) begin
            bad++; $display("FAIL gl_dead%0d got=%b/%b required=0000/01", i, hbIn, deadBusy);
         end
      end
      tick();
      total++; if (hbIn !== 4'b0010 || deadBusy !== 2'b00) begin bad++; $display("FAIL gl_resume got=%b/%b required=0010/00", hbIn, deadBusy); end
   endtask
   task automatic test_disable();
      do_reset();
      duty = 16'hFF00; motorEn = 2'b10; motorIn = 4'b1000;
      repeat (12) tick();
      motorEn = 2'b00;
      tick();
      total++; if (hbIn !== 4'b1000) begin bad++; $display("FAIL dis_latency got=%b required=1000", hbIn); end
      for (int i = 0; i < DC; i++) begin
         tick();
         total++;
         if (hbIn !== 4'b0000 || deadBusy !== 2'b10 || hbEn !== 2'b00) begin
            bad++; $display("FAIL dis_dead%0d got=%b/%b/%b required=0000/10/00", i, hbIn, deadBusy, hbEn);
         end
      end
      tick();
      total++; if (hbIn !== 4'b0000 || deadBusy !== 2'b00 || hbEn !== 2'b00) begin bad++; $display("FAIL dis_stop got=%b/%b/%b required=0000/00/00", hbIn, deadBusy, hbEn); end
      motorEn = 2'b10; motorIn = 4'b0100;
      tick();
      total++; if (hbIn !== 4'b0000) begin bad++; $display("FAIL dis_reen_1clk got=%b required=0000", hbIn); end
      tick();
      total++; if (hbIn !== 4'b0100 || deadBusy !== 2'b00) begin bad++; $display("FAIL dis_reen_run got=%b/%b required=0100/00", hbIn, deadBusy); end
   endtask
   task automatic test_duty_decrease();
      int r, l;
      do_reset();
      duty = 16'h00FF; motorEn = 2'b01; motorIn = 4'b0010;
      repeat (12) tick();
      measure(r, l);
      total++; if (r != 255) begin bad++; $display("FAIL dd_full got=%0d required=255", r); end
      duty = 16'h0020;
      repeat (2) tick();
      measure(r, l);
      total++; if (r != 32) begin bad++; $display("FAIL dd_32 got=%0d required=32", r); end
      duty = 16'h0000;
      repeat (2) tick();
      measure(r, l);
      total++; if (r != 0) begin bad++; $display("FAIL dd_zero got=%0d required=0", r); end
      total++; if (hbIn !== 4'b0010) begin bad++; $display("FAIL dd_still_run got=%b required=0010", hbIn); end
   endtask
   initial begin
      test_reset();
      test_soft_start();
      test_ramp_clamp();
      test_reversal();
      test_glitch();
      test_disable();
      test_duty_decrease();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
